// File: rtl/onehot_encoder8_3_pipe.sv
// Registered 8-to-3 one-hot encoder with valid/ready handshakes, a single
// output register with backpressure, and running beat/error counters.
module onehot_encoder8_3_pipe #(
    parameter int CNT_W         = 8,
    parameter bit PRIORITY_HIGH = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       out_a,
    output logic             out_err,
    output logic             out_zero,
    input  logic             err_clr,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] beat_count
);

    logic [3:0] ones;
    logic [2:0] hi_idx;
    logic [2:0] lo_idx;
    logic [2:0] enc_a;
    logic       enc_err;
    logic       enc_zero;
    logic       accept;

    // Highest set bit wins in the ascending scan, lowest in the descending one.
    always_comb begin
        ones   = '0;
        hi_idx = '0;
        lo_idx = '0;
        for (int i = 0; i < 8; i++) begin
            ones = ones + {3'b000, in_y[i]};
            if (in_y[i]) hi_idx = 3'(i);
        end
        for (int i = 7; i >= 0; i--) begin
            if (in_y[i]) lo_idx = 3'(i);
        end
        enc_zero = (in_y == 8'h00);
        enc_err  = (ones != 4'd1);
        enc_a    = PRIORITY_HIGH ? hi_idx : lo_idx;
    end

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // in_y only reaches state through an accept, so X on an idle bus is harmless.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_a     <= '0;
            out_err   <= 1'b0;
            out_zero  <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_a     <= enc_a;
            out_err   <= enc_err;
            out_zero  <= enc_zero;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Clear beats a same-cycle increment; the error count sticks at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_count  <= '0;
            beat_count <= '0;
        end else begin
            if (accept) beat_count <= beat_count + CNT_W'(1);
            if (err_clr) begin
                err_count <= '0;
            end else if (accept && enc_err && (err_count != {CNT_W{1'b1}})) begin
                err_count <= err_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_onehot_encoder8_3_pipe.sv
// Self-checking bench: vector table, directed handshake/counter corner cases,
// decoder loopback and randomized traffic against a behavioural model.
module tb_onehot_encoder8_3_pipe;

    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset, in_valid, out_ready, err_clr;
    logic [7:0]    in_y;
    logic          in_ready, out_valid, out_err, out_zero;
    logic [2:0]    out_a;
    logic [CW-1:0] err_count, beat_count;
    logic          in_ready_lo, out_valid_lo, out_err_lo, out_zero_lo;
    logic [2:0]    out_a_lo;
    logic [CW-1:0] err_count_lo, beat_count_lo;

    int checks = 0;
    int errors = 0;

    bit m_valid;
    int m_a_hi, m_a_lo, m_err, m_zero, m_ecnt, m_bcnt;

    typedef struct {
        logic [7:0] y;
        int         a_hi;
        int         a_lo;
        int         err;
        int         zero;
    } vec_t;
    vec_t tbl[$];

    onehot_encoder8_3_pipe #(.CNT_W(CW), .PRIORITY_HIGH(1'b1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_y(in_y), .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a),
        .out_err(out_err), .out_zero(out_zero), .err_clr(err_clr),
        .err_count(err_count), .beat_count(beat_count)
    );

    onehot_encoder8_3_pipe #(.CNT_W(CW), .PRIORITY_HIGH(1'b0)) dut_lo (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_lo),
        .in_y(in_y), .out_valid(out_valid_lo), .out_ready(out_ready), .out_a(out_a_lo),
        .out_err(out_err_lo), .out_zero(out_zero_lo), .err_clr(err_clr),
        .err_count(err_count_lo), .beat_count(beat_count_lo)
    );

    always #5 clk = ~clk;

    function automatic int floor_log2(int v);
        int n = 0;
        while (v > 1) begin
            v = v >> 1;
            n++;
        end
        return n;
    endfunction

    function automatic int ref_hi(int v);
        return (v == 0) ? 0 : floor_log2(v);
    endfunction

    function automatic int ref_lo(int v);
        return (v == 0) ? 0 : floor_log2(v & -v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive at negedge, step the model, compare #1 after posedge.
    task automatic cycle(input bit v, input logic [7:0] y, input bit ordy,
                         input bit clr, input bit rst);
        bit acc;
        int w;
        @(negedge clk);
        reset = rst; in_valid = v; in_y = y; out_ready = ordy; err_clr = clr;
        #1;
        if (!rst) begin
            chk("in_ready", {31'b0, in_ready}, {31'b0, (!m_valid || ordy)});
            chk("in_ready_lo", {31'b0, in_ready_lo}, {31'b0, (!m_valid || ordy)});
        end
        acc = v && (!m_valid || ordy);
        if (rst) begin
            m_valid = 0; m_a_hi = 0; m_a_lo = 0; m_err = 0; m_zero = 0;
            m_ecnt = 0; m_bcnt = 0;
        end else begin
            if (acc) begin
                w       = int'(y);
                m_valid = 1;
                m_zero  = (w == 0);
                m_err   = ($countones(y) != 1);
                m_a_hi  = ref_hi(w);
                m_a_lo  = ref_lo(w);
                m_bcnt  = (m_bcnt + 1) % (CMAX + 1);
            end else if (ordy) begin
                m_valid = 0;
            end
            if (clr) m_ecnt = 0;
            else if (acc && m_err != 0 && m_ecnt < CMAX) m_ecnt++;
        end
        @(posedge clk);
        #1;
        chk("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
        chk("out_a", {29'b0, out_a}, m_a_hi);
        chk("out_err", {31'b0, out_err}, m_err);
        chk("out_zero", {31'b0, out_zero}, m_zero);
        chk("err_count", {28'b0, err_count}, m_ecnt);
        chk("beat_count", {28'b0, beat_count}, m_bcnt);
        chk("out_a_lo", {29'b0, out_a_lo}, m_a_lo);
        chk("out_valid_lo", {31'b0, out_valid_lo}, {31'b0, m_valid});
    endtask

    initial begin
        logic [7:0] ry;
        bit         rv;
        m_valid = 0; m_a_hi = 0; m_a_lo = 0; m_err = 0; m_zero = 0; m_ecnt = 0; m_bcnt = 0;
        reset = 1; in_valid = 0; in_y = '0; out_ready = 1; err_clr = 0;

        for (int i = 0; i < 8; i++) tbl.push_back('{8'h01 << i, i, i, 0, 0});
        tbl.push_back('{8'h00, 0, 0, 1, 1});
        tbl.push_back('{8'hA4, 7, 2, 1, 0});
        tbl.push_back('{8'hFF, 7, 0, 1, 0});
        tbl.push_back('{8'h81, 7, 0, 1, 0});
        tbl.push_back('{8'h18, 4, 3, 1, 0});
        tbl.push_back('{8'h60, 6, 5, 1, 0});

        cycle(0, 8'h00, 1, 0, 1);
        cycle(0, 8'h00, 1, 0, 1);

        // Streaming vector table at full throughput.
        foreach (tbl[i]) begin
            cycle(1, tbl[i].y, 1, 0, 0);
            chk("tbl_a_hi", {29'b0, out_a}, tbl[i].a_hi);
            chk("tbl_a_lo", {29'b0, out_a_lo}, tbl[i].a_lo);
            chk("tbl_err", {31'b0, out_err}, tbl[i].err);
            chk("tbl_zero", {31'b0, out_zero}, tbl[i].zero);
            if (i == 7) begin
                chk("onehot_beats", {28'b0, beat_count}, 8);
                chk("onehot_errs", {28'b0, err_count}, 0);
            end
            if (i == 9) chk("zero_a4_errs", {28'b0, err_count}, 2);
        end
        cycle(0, 8'h00, 1, 0, 0);

        // Backpressure: hold result 4 while 02 waits, then consume and accept together.
        cycle(1, 8'h10, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cycle(1, 8'h02, 0, 0, 0);
            chk("bp_hold_a", {29'b0, out_a}, 4);
            chk("bp_ready", {31'b0, in_ready}, 0);
        end
        cycle(1, 8'h02, 1, 0, 0);
        chk("bp_next_a", {29'b0, out_a}, 1);
        cycle(0, 8'h00, 1, 0, 0);

        // Saturation and wrap, then clear racing an increment.
        cycle(0, 8'h00, 1, 0, 1);
        for (int i = 0; i < 17; i++) cycle(1, 8'h00, 1, 0, 0);
        chk("sat_err", {28'b0, err_count}, 15);
        chk("wrap_beat", {28'b0, beat_count}, 1);
        cycle(1, 8'h00, 1, 1, 0);
        chk("clr_err", {28'b0, err_count}, 0);
        chk("clr_beat", {28'b0, beat_count}, 2);

        // Reset during a stalled result: it must never reappear.
        cycle(1, 8'h08, 0, 0, 0);
        cycle(1, 8'h20, 0, 0, 0);
        cycle(1, 8'h20, 0, 0, 1);
        chk("rst_valid", {31'b0, out_valid}, 0);
        cycle(0, 8'h00, 1, 0, 0);
        chk("rst_stale", {31'b0, out_valid}, 0);

        // Loopback through a behavioural 3-to-8 decoder.
        for (int a = 0; a < 8; a++) begin
            cycle(1, 8'h01 << a, 1, 0, 0);
            chk("loopback_a", {29'b0, out_a}, a);
        end

        // Random traffic, including X on an idle bus.
        for (int i = 0; i < 400; i++) begin
            rv = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0:       ry = 8'h01 << $urandom_range(0, 7);
                1:       ry = 8'h00;
                default: ry = 8'($urandom);
            endcase
            if (!rv && $urandom_range(0, 1) == 1) ry = 8'hxx;
            cycle(rv, ry, ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 63) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
